// File: rtl/prng_pkg.sv
// Shared types and helpers for the arbitrated 8-bit LFSR random source.
package prng_pkg;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    LOAD     = 2'd1,
    RUN      = 2'd2
  } state_t;

  localparam logic [7:0] TAP           = 8'hB8;
  localparam logic [7:0] ZERO_SEED_SUB = 8'h01;
  localparam int         PERIOD        = 255;

  // Fibonacci step, taps 8,6,5,4: maximal length over the 255 non-zero states.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & TAP)};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req at or after rr_ptr, circularly.
// Zero latency; gnt is all-zero when no request is pending.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin shared LFSR source: one word per grant, response one cycle after gnt.
// Requesters hold req until granted; a pending seed blocks grants for two cycles.
module prng_arbiter
  import prng_pkg::*;
#(
  parameter int N       = 8,
  parameter int NUM_REQ = 4,
  parameter int PERIOD  = prng_pkg::PERIOD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       seed_valid,
  input  logic [N-1:0]               seed_data,
  output logic                       seed_ready,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [N-1:0]               rsp_data,
  output logic                       period_done,
  output logic                       seeded
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(PERIOD + 1);

  if (N != 8) begin : g_bad_width
    $error("prng_arbiter: taps are fixed, only N=8 is supported");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("prng_arbiter: NUM_REQ must be 2..8");
  end
  if (PERIOD != (1 << N) - 1) begin : g_bad_period
    $error("prng_arbiter: PERIOD must be 2^N-1");
  end

  state_t             state;
  logic [N-1:0]       lfsr;
  logic [N-1:0]       seed_q;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  // A seed request in RUN wins over any pending word request.
  assign grant      = reset && (state == RUN) && !seed_valid && (|req);
  assign gnt        = grant ? arb_gnt : '0;
  assign seed_ready = reset && (state != LOAD);
  assign seeded     = (state == RUN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= UNSEEDED;
      lfsr        <= '0;
      seed_q      <= '0;
      cnt         <= '0;
      rr_ptr      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      period_done <= 1'b0;
    end else begin
      rsp_valid   <= grant;
      period_done <= grant && (cnt == CNT_W'(PERIOD - 1));
      case (state)
        UNSEEDED: begin
          if (seed_valid) begin
            seed_q <= seed_data;
            state  <= LOAD;
          end
        end
        LOAD: begin
          // The all-zero state would lock the LFSR, so substitute a non-zero seed.
          lfsr  <= (seed_q == '0) ? N'(ZERO_SEED_SUB) : seed_q;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (seed_valid) begin
            seed_q <= seed_data;
            state  <= LOAD;
          end else if (grant) begin
            rsp_id   <= arb_idx;
            rsp_data <= lfsr;
            lfsr     <= lfsr_next(lfsr);
            rr_ptr   <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            cnt      <= (cnt == CNT_W'(PERIOD - 1)) ? '0 : cnt + 1'b1;
          end
        end
        default: state <= UNSEEDED;
      endcase
    end
  end

endmodule

// File: doc/prng_arbiter.md
Name: prng_arbiter

Overview:
Shares one 8-bit maximal-length LFSR pseudo-random source among NUM_REQ requesters.
- Owns seeding, lock-up avoidance, round-robin arbitration and per-period bookkeeping.
- Each grant delivers exactly one random word and advances the LFSR once.
- The LFSR is held, not free-running, when no grant occurs.
- Sits between the test-pattern consumers and the random source, as the single point through which all random words are drawn.

Parameters:
- N, 8, LFSR width. Only 8 is supported because the taps are fixed; an elaboration check rejects other values.
- NUM_REQ, 4, number of requesters (2..8).
- PERIOD, 255, words per full LFSR period (2^N-1).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- seed_valid  input  1  seed load request.
- seed_data  input  N  seed value.
- seed_ready  output  1  seed accepted this cycle when high with seed_valid.
- req  input  NUM_REQ  per-requester word request; level, held until granted.
- gnt  output  NUM_REQ  one-hot grant, combinational from req, state and pointer.
- rsp_valid  output  1  registered; one-cycle pulse, one cycle after the grant.
- rsp_id  output  $clog2(NUM_REQ)  index of the requester owning rsp_data.
- rsp_data  output  N  random word.
- period_done  output  1  registered pulse coincident with the PERIOD-th rsp_valid since the last seed.
- seeded  output  1  high in state RUN.

Behaviour:
- Reset is synchronous: on a clk edge with reset=0, the block returns to its reset state.
  - State goes to UNSEEDED.
  - lfsr, cnt, rr_ptr, rsp_valid, rsp_id, rsp_data, period_done and seeded all clear to 0.
  - gnt stays 0 while reset=0.
  - A response in flight is dropped; no rsp_valid follows.
- LFSR step: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- States:
  - UNSEEDED: gnt=0; seed_ready=1; seed_valid -> LOAD.
  - LOAD (one cycle): lfsr <= (seed_q==0) ? 8'h01 : seed_q, where seed_q is the seed captured at acceptance; cnt <= 0; gnt=0; seed_ready=0; -> RUN.
  - RUN: seeded=1; seed_ready=1.
    - If seed_valid: the seed wins; gnt=0 this cycle; -> LOAD.
    - Else if |req: grant to the first requesting index at or after rr_ptr, searching circularly.
- On a grant to index k:
  - Next cycle: rsp_valid=1, rsp_id=k, rsp_data = lfsr value before the step.
  - lfsr steps once; rr_ptr <= (k+1) mod NUM_REQ.
  - cnt <= (cnt==PERIOD-1) ? 0 : cnt+1.
  - period_done=1 alongside rsp_valid when the pre-increment cnt==PERIOD-1.
- At most one grant per cycle, so throughput is one word per cycle.
- A requester may drop req before it is granted; it is then not served.
- An ungranted req is never starved: round-robin bounds the wait to NUM_REQ-1 grants.
- Words are never repeated within a period. After PERIOD grants, lfsr equals the loaded seed again; this wrap is natural and does not reseed.
- rsp_data holds its last value when rsp_valid=0; rsp_id likewise.
- A reseed does not reset rr_ptr.

Decomposition:
- Package prng_pkg holds:
  - the state enum {UNSEEDED, LOAD, RUN};
  - localparams TAP mask 8'hB8, ZERO_SEED_SUB 8'h01 and PERIOD;
  - the function lfsr_next().
- One sub-module, rr_arbiter (req, rr_ptr -> one-hot gnt, encoded index), reused by other shared-resource controllers.
- The LFSR register and counter stay inline.

Test Plan:
- Seed 8'h01, req=4'b0001 held for 5 cycles -> rsp_data 01,02,04,08,11; all rsp_id=0; each rsp_valid one cycle after its gnt.
- After seeding, req=4'b1111 held -> gnt 0001,0010,0100,1000,0001; rsp_id 0,1,2,3,0; one word per cycle.
- Seed 8'h00 -> first rsp_data 8'h01; the LFSR never locks at zero.
- Seed 8'hA5, 256 single-requester grants:
  - period_done pulses only on the 255th response;
  - the 256th rsp_data equals 8'hA5;
  - all 255 words are distinct.
- In RUN with req=4'b0011, assert seed_valid=1 with seed_data=8'h3C -> gnt=0 that cycle and the next (LOAD); the next rsp_data is 3C; cnt restarts and period_done lands 255 grants later.
- Pull reset low for one edge on the cycle after a grant -> no rsp_valid; seeded=0; gnt=0 with req held until a new seed is accepted.
